// File: rtl/rhs_session_scheduler.sv
// Session sequencer in front of rhs_256: turns host requests into fixed-width start/stop strobes
// and a recording level, enforcing ordering, stim lockout and config/zcheck timeouts.
module rhs_session_scheduler #(
  parameter int START_PULSE_CYCLES  = 16,
  parameter int SETTLE_FRAMES       = 8,
  parameter int STIM_LOCKOUT_FRAMES = 64,
  parameter int TIMEOUT_CYCLES      = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_config,
  input  logic       req_zcheck,
  input  logic       req_record_on,
  input  logic       req_record_off,
  input  logic       req_stim_finite,
  input  logic       req_stim_inf_start,
  input  logic       req_stim_inf_stop,
  input  logic       config_done,
  input  logic       zcheck_done,
  input  logic       frame_tick,
  output logic       config_start,
  output logic       zcheck_start,
  output logic       stim_finite_mode_start,
  output logic       stim_infinite_mode_start,
  output logic       stim_infinite_mode_stop,
  output logic       record_start,
  output logic       configured,
  output logic       busy,
  output logic       rejected,
  output logic       timeout_err,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CONFIG   = 3'd1;
  localparam logic [2:0] S_ZCHECK   = 3'd2;
  localparam logic [2:0] S_SETTLE   = 3'd3;
  localparam logic [2:0] S_RECORD   = 3'd4;
  localparam logic [2:0] S_STIM_INF = 3'd5;
  localparam logic [2:0] S_STOPPING = 3'd6;

  localparam logic [2:0] W_NONE      = 3'd0;
  localparam logic [2:0] W_REC_OFF   = 3'd1;
  localparam logic [2:0] W_INF_STOP  = 3'd2;
  localparam logic [2:0] W_CONFIG    = 3'd3;
  localparam logic [2:0] W_ZCHECK    = 3'd4;
  localparam logic [2:0] W_REC_ON    = 3'd5;
  localparam logic [2:0] W_FINITE    = 3'd6;
  localparam logic [2:0] W_INF_START = 3'd7;

  localparam logic [2:0] STB_CONFIG    = 3'd0;
  localparam logic [2:0] STB_ZCHECK    = 3'd1;
  localparam logic [2:0] STB_FINITE    = 3'd2;
  localparam logic [2:0] STB_INF_START = 3'd3;
  localparam logic [2:0] STB_INF_STOP  = 3'd4;

  localparam logic [7:0]  PULSE_LAST  = 8'(START_PULSE_CYCLES - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_FRAMES - 1);
  localparam logic [15:0] LOCK_LOAD   = 16'(STIM_LOCKOUT_FRAMES);
  localparam logic [23:0] TMO_LAST    = 24'(TIMEOUT_CYCLES - 1);

  logic        strobe_act;
  logic [2:0]  strobe_sel;
  logic [7:0]  strobe_cnt;
  logic        pend_off;
  logic [7:0]  settle_cnt;
  logic [15:0] lockout;
  logic [23:0] tmo_cnt;
  logic        rec_off_eff;
  logic [2:0]  win;

  // A record_off deferred behind a strobe competes as if it had just arrived.
  always_comb begin
    rec_off_eff = req_record_off | (pend_off & ~strobe_act);
    win = W_NONE;
    if (rec_off_eff)             win = W_REC_OFF;
    else if (req_stim_inf_stop)  win = W_INF_STOP;
    else if (req_config)         win = W_CONFIG;
    else if (req_zcheck)         win = W_ZCHECK;
    else if (req_record_on)      win = W_REC_ON;
    else if (req_stim_finite)    win = W_FINITE;
    else if (req_stim_inf_start) win = W_INF_START;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      strobe_act   <= 1'b0;
      strobe_sel   <= STB_CONFIG;
      strobe_cnt   <= '0;
      pend_off     <= 1'b0;
      settle_cnt   <= '0;
      lockout      <= '0;
      tmo_cnt      <= '0;
      record_start <= 1'b0;
      configured   <= 1'b0;
      rejected     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      rejected <= 1'b0;
      if (frame_tick && lockout != '0) lockout <= lockout - 16'd1;
      if (strobe_act) begin
        if (strobe_cnt == '0) strobe_act <= 1'b0;
        else strobe_cnt <= strobe_cnt - 8'd1;
      end else begin
        pend_off <= 1'b0;
      end

      case (state)
        S_CONFIG, S_ZCHECK: begin
          tmo_cnt <= tmo_cnt + 24'd1;
          // Done beats timeout when both land on the same cycle.
          if ((state == S_CONFIG && config_done) || (state == S_ZCHECK && zcheck_done)) begin
            state      <= S_IDLE;
            strobe_act <= 1'b0;
            if (state == S_CONFIG) configured <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= S_IDLE;
            strobe_act  <= 1'b0;
            timeout_err <= 1'b1;
          end
          if (win != W_NONE && win != W_REC_OFF) rejected <= 1'b1;
        end

        S_STOPPING: begin
          if (win != W_NONE) rejected <= 1'b1;
          if (strobe_act && strobe_cnt == '0) begin
            state        <= S_IDLE;
            record_start <= 1'b0;
          end
        end

        S_IDLE, S_SETTLE, S_RECORD, S_STIM_INF: begin
          if (state == S_SETTLE && frame_tick) begin
            if (settle_cnt == SETTLE_LAST) state <= S_RECORD;
            else settle_cnt <= settle_cnt + 8'd1;
          end
          if (win != W_NONE) begin
            if (strobe_act) begin
              if (win == W_REC_OFF) pend_off <= 1'b1;
              else rejected <= 1'b1;
            end else begin
              case (state)
                S_IDLE: begin
                  if (win == W_CONFIG || win == W_ZCHECK) begin
                    state       <= (win == W_CONFIG) ? S_CONFIG : S_ZCHECK;
                    strobe_act  <= 1'b1;
                    strobe_sel  <= (win == W_CONFIG) ? STB_CONFIG : STB_ZCHECK;
                    strobe_cnt  <= PULSE_LAST;
                    tmo_cnt     <= '0;
                    timeout_err <= 1'b0;
                  end else if (win == W_REC_ON && configured) begin
                    state        <= S_SETTLE;
                    record_start <= 1'b1;
                    settle_cnt   <= '0;
                  end else begin
                    rejected <= 1'b1;
                  end
                end
                S_SETTLE: begin
                  if (win == W_REC_OFF) begin
                    state        <= S_IDLE;
                    record_start <= 1'b0;
                  end else begin
                    rejected <= 1'b1;
                  end
                end
                S_RECORD: begin
                  if (win == W_REC_OFF) begin
                    state        <= S_IDLE;
                    record_start <= 1'b0;
                  end else if ((win == W_FINITE || win == W_INF_START) && lockout == '0) begin
                    strobe_act <= 1'b1;
                    strobe_cnt <= PULSE_LAST;
                    if (win == W_FINITE) begin
                      strobe_sel <= STB_FINITE;
                      lockout    <= LOCK_LOAD;
                    end else begin
                      strobe_sel <= STB_INF_START;
                      state      <= S_STIM_INF;
                    end
                  end else begin
                    rejected <= 1'b1;
                  end
                end
                default: begin
                  if (win == W_INF_STOP || win == W_REC_OFF) begin
                    strobe_act <= 1'b1;
                    strobe_sel <= STB_INF_STOP;
                    strobe_cnt <= PULSE_LAST;
                    state      <= (win == W_INF_STOP) ? S_RECORD : S_STOPPING;
                  end else begin
                    rejected <= 1'b1;
                  end
                end
              endcase
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign config_start             = strobe_act && (strobe_sel == STB_CONFIG);
  assign zcheck_start             = strobe_act && (strobe_sel == STB_ZCHECK);
  assign stim_finite_mode_start   = strobe_act && (strobe_sel == STB_FINITE);
  assign stim_infinite_mode_start = strobe_act && (strobe_sel == STB_INF_START);
  assign stim_infinite_mode_stop  = strobe_act && (strobe_sel == STB_INF_STOP);
  assign busy = (state == S_CONFIG) || (state == S_ZCHECK) || (state == S_SETTLE) || strobe_act;

endmodule

// File: tb/tb_rhs_session_scheduler.sv
// Directed bench for rhs_session_scheduler; timeout shortened to 200 cycles to keep runtime small.
module tb_rhs_session_scheduler;

  logic clk, rst;
  logic req_config, req_zcheck, req_record_on, req_record_off;
  logic req_stim_finite, req_stim_inf_start, req_stim_inf_stop;
  logic config_done, zcheck_done, frame_tick;
  logic config_start, zcheck_start, stim_finite_mode_start;
  logic stim_infinite_mode_start, stim_infinite_mode_stop;
  logic record_start, configured, busy, rejected, timeout_err;
  logic [2:0] state;

  int total = 0;
  int passes = 0;
  int fails = 0;
  int n;

  rhs_session_scheduler #(.TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .rst(rst),
    .req_config(req_config), .req_zcheck(req_zcheck),
    .req_record_on(req_record_on), .req_record_off(req_record_off),
    .req_stim_finite(req_stim_finite), .req_stim_inf_start(req_stim_inf_start),
    .req_stim_inf_stop(req_stim_inf_stop),
    .config_done(config_done), .zcheck_done(zcheck_done), .frame_tick(frame_tick),
    .config_start(config_start), .zcheck_start(zcheck_start),
    .stim_finite_mode_start(stim_finite_mode_start),
    .stim_infinite_mode_start(stim_infinite_mode_start),
    .stim_infinite_mode_stop(stim_infinite_mode_stop),
    .record_start(record_start), .configured(configured), .busy(busy),
    .rejected(rejected), .timeout_err(timeout_err), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    rst = 1'b0;
    {req_config, req_zcheck, req_record_on, req_record_off} = '0;
    {req_stim_finite, req_stim_inf_start, req_stim_inf_stop} = '0;
    {config_done, zcheck_done, frame_tick} = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_record", 32'(record_start), 0);
    chk("rst_configured", 32'(configured), 0);
    step(); step();
    rst = 1'b0;
    step();

    // record_on before any config is refused
    req_record_on = 1'b1; step(); req_record_on = 1'b0;
    chk("recon_unconf_rej", 32'(rejected), 1);
    chk("recon_unconf_rec", 32'(record_start), 0);
    step();
    chk("rej_one_cycle", 32'(rejected), 0);

    // config strobe width and late done
    req_config = 1'b1; step(); req_config = 1'b0;
    chk("cfg_state", 32'(state), 1);
    chk("cfg_busy", 32'(busy), 1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (config_start) n++;
      step();
    end
    chk("cfg_strobe_width", 32'(n), 16);
    chk("cfg_wait_state", 32'(state), 1);
    config_done = 1'b1; step(); config_done = 1'b0;
    chk("cfg_done_state", 32'(state), 0);
    chk("cfg_configured", 32'(configured), 1);
    chk("cfg_done_busy", 32'(busy), 0);

    // config timeout
    req_config = 1'b1; step(); req_config = 1'b0;
    n = 0;
    while (state == 3'd1 && n < 400) begin
      n++;
      step();
    end
    chk("tmo_cycles", 32'(n), 200);
    chk("tmo_err", 32'(timeout_err), 1);
    chk("tmo_state", 32'(state), 0);

    // zcheck clears error; done during strobe cuts it short
    req_zcheck = 1'b1; step(); req_zcheck = 1'b0;
    chk("zc_err_clear", 32'(timeout_err), 0);
    chk("zc_state", 32'(state), 2);
    chk("zc_strobe", 32'(zcheck_start), 1);
    step(); step(); step();
    zcheck_done = 1'b1; step(); zcheck_done = 1'b0;
    chk("zc_cut_strobe", 32'(zcheck_start), 0);
    chk("zc_cut_state", 32'(state), 0);

    // record, settle, stim lockout
    req_record_on = 1'b1; step(); req_record_on = 1'b0;
    chk("settle_state", 32'(state), 3);
    chk("settle_rec", 32'(record_start), 1);
    ticks(3);
    req_stim_finite = 1'b1; step(); req_stim_finite = 1'b0;
    chk("settle_stim_rej", 32'(rejected), 1);
    chk("settle_no_strobe", 32'(stim_finite_mode_start), 0);
    ticks(4);
    chk("settle_7_ticks", 32'(state), 3);
    tick();
    chk("record_state", 32'(state), 4);
    chk("record_busy", 32'(busy), 0);
    req_stim_finite = 1'b1; step(); req_stim_finite = 1'b0;
    chk("fin1_strobe", 32'(stim_finite_mode_start), 1);
    chk("fin1_no_rej", 32'(rejected), 0);
    for (int i = 0; i < 16; i++) step();
    chk("fin1_strobe_end", 32'(stim_finite_mode_start), 0);
    ticks(10);
    req_stim_finite = 1'b1; step(); req_stim_finite = 1'b0;
    chk("lock10_rej", 32'(rejected), 1);
    ticks(53);
    req_stim_finite = 1'b1; step(); req_stim_finite = 1'b0;
    chk("lock63_rej", 32'(rejected), 1);
    chk("lock63_no_strobe", 32'(stim_finite_mode_start), 0);
    tick();
    req_stim_finite = 1'b1; step(); req_stim_finite = 1'b0;
    chk("lock64_strobe", 32'(stim_finite_mode_start), 1);
    chk("lock64_no_rej", 32'(rejected), 0);
    step();
    req_stim_inf_start = 1'b1; step(); req_stim_inf_start = 1'b0;
    chk("overlap_rej", 32'(rejected), 1);
    chk("overlap_state", 32'(state), 4);
    n = 0;
    while (stim_finite_mode_start && n < 40) begin
      n++;
      step();
    end
    chk("fin2_strobe_end", 32'(stim_finite_mode_start), 0);
    ticks(64);

    // record_off outranks stim_finite in the same cycle
    req_record_off = 1'b1; req_stim_finite = 1'b1; step();
    req_record_off = 1'b0; req_stim_finite = 1'b0;
    chk("prio_state", 32'(state), 0);
    chk("prio_rec", 32'(record_start), 0);
    chk("prio_no_stim", 32'(stim_finite_mode_start), 0);
    chk("prio_no_rej", 32'(rejected), 0);

    // infinite stim, record_off deferred behind the start strobe
    req_record_on = 1'b1; step(); req_record_on = 1'b0;
    ticks(8);
    chk("rec2_state", 32'(state), 4);
    req_stim_inf_start = 1'b1; step(); req_stim_inf_start = 1'b0;
    chk("inf_state", 32'(state), 5);
    chk("inf_strobe", 32'(stim_infinite_mode_start), 1);
    step(); step();
    req_record_off = 1'b1; step(); req_record_off = 1'b0;
    chk("inf_off_no_rej", 32'(rejected), 0);
    chk("inf_off_deferred", 32'(state), 5);
    n = 0;
    while (state != 3'd6 && n < 40) begin
      n++;
      step();
    end
    chk("stop_state", 32'(state), 6);
    chk("stop_rec_hold", 32'(record_start), 1);
    n = 0;
    while (stim_infinite_mode_stop && n < 40) begin
      n++;
      step();
    end
    chk("stop_width", 32'(n), 16);
    chk("stop_exit_state", 32'(state), 0);
    chk("stop_exit_rec", 32'(record_start), 0);

    // asynchronous reset in the middle of config_start
    req_config = 1'b1; step(); req_config = 1'b0;
    step(); step();
    chk("pre_rst_strobe", 32'(config_start), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_strobe", 32'(config_start), 0);
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_configured", 32'(configured), 0);
    chk("async_rst_busy", 32'(busy), 0);
    step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/rhs_session_scheduler.md
# rhs_session_scheduler

Host-side session controller that sits between the command/register layer and `rhs_256`. It serialises configuration, impedance-check, recording and stimulation requests into the start and stop strobes `rhs_256` expects. It enforces legal ordering: no config or zcheck while recording, no stimulation before recording has settled, and no overlapping finite trains. It also times out hung config/zcheck operations.

## Interface
- `START_PULSE_CYCLES`, 16: width in clk cycles of every start/stop strobe driven to `rhs_256`.
- `SETTLE_FRAMES`, 8: `frame_tick` pulses required after `record_start` rises before stim requests are legal.
- `STIM_LOCKOUT_FRAMES`, 64: frames after a finite-stim strobe during which further stim requests are rejected.
- `TIMEOUT_CYCLES`, 1000000: maximum clk cycles in CONFIG/ZCHECK before an error abort (24-bit counter).
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `req_config`, `req_zcheck`, `req_record_on`, `req_record_off`, `req_stim_finite`, `req_stim_inf_start`, `req_stim_inf_stop` in 1 each: single-cycle host request pulses.
- `config_done`, `zcheck_done` in 1: completion pulses from `rhs_256`.
- `frame_tick` in 1: one-cycle pulse per completed CS sample frame.
- `config_start`, `zcheck_start`, `stim_finite_mode_start`, `stim_infinite_mode_start`, `stim_infinite_mode_stop` out 1: strobes to `rhs_256`.
- `record_start` out 1: recording level to `rhs_256`.
- `configured` out 1: sticky; set on first `config_done`.
- `busy` out 1: high in CONFIG, ZCHECK, SETTLE, and while any strobe is active.
- `rejected` out 1: one-cycle pulse when a request is illegal in the current state.
- `timeout_err` out 1: sticky until the next accepted `req_config`/`req_zcheck`.
- `state` out 3: IDLE=0, CONFIG=1, ZCHECK=2, SETTLE=3, RECORD=4, STIM_INF=5, STOPPING=6.

## Operation
- **IDLE**
  - `req_config` → CONFIG, fire `config_start`.
  - `req_zcheck` → ZCHECK, fire `zcheck_start`.
  - `req_record_on` is accepted only if `configured`; it → SETTLE and raises `record_start`. Otherwise `rejected`.
  - All stim requests and `req_record_off` → `rejected`.
- **CONFIG / ZCHECK**
  - The matching done pulse → IDLE. In CONFIG it also sets `configured`.
  - The timeout counter reaching TIMEOUT_CYCLES-1 → IDLE and sets `timeout_err`.
  - All requests except `req_record_off` → `rejected`. `req_record_off` is ignored silently.
- **SETTLE**
  - Count `frame_tick`; at SETTLE_FRAMES → RECORD.
  - `req_record_off` → IDLE with `record_start` low.
  - Stim requests → `rejected`.
- **RECORD**
  - `req_stim_finite` is accepted if lockout = 0: fire `stim_finite_mode_start` and load lockout = STIM_LOCKOUT_FRAMES. Lockout decrements on `frame_tick` and saturates at 0.
  - `req_stim_inf_start` is accepted if lockout = 0: fire `stim_infinite_mode_start`, → STIM_INF.
  - `req_record_off` → IDLE; `record_start` falls the next cycle.
  - `req_config`, `req_zcheck`, `req_record_on` → `rejected`.
- **STIM_INF**
  - `req_stim_inf_stop` fires `stim_infinite_mode_stop`, → RECORD.
  - `req_record_off` fires `stim_infinite_mode_stop` and → STOPPING. When the strobe completes → IDLE, with `record_start` low.
  - Other requests → `rejected`.
- **STOPPING**: all requests → `rejected`.
- **Simultaneous requests**: priority is record_off > stim_inf_stop > config > zcheck > record_on > stim_finite > stim_inf_start. Only the winner is evaluated. Losers are dropped without `rejected`.
- **Strobe overlap**: only one strobe is active at a time. Any request arriving while a strobe is active → `rejected`, except `req_record_off`. `req_record_off` is latched and executed the cycle after the strobe ends.
- **Reset**
  - All outputs 0, `state` = IDLE, counters 0.
  - Reset mid-strobe or mid-record drops all outputs immediately (asynchronously).

## Timing
- An accepted request at cycle N gives the state change and strobe high at N+1. The strobe stays high through N+START_PULSE_CYCLES.
- `rejected` is high at N+1 for exactly one cycle.
- `record_start` rises at N+1 after an accepted `req_record_on`. It falls at N+1 after `req_record_off` (from RECORD/SETTLE), or on the cycle STOPPING exits.
- The timeout counter clears on CONFIG/ZCHECK entry and increments every cycle. A done pulse in the same cycle as timeout wins: no error.
- A done pulse arriving during the start strobe is honoured. The strobe is cut short and the state → IDLE.
- SETTLE → RECORD occurs the cycle after the SETTLE_FRAMES-th `frame_tick`.

## Test plan
- Reset, then `req_record_on` → `rejected` pulse, `record_start` stays 0. Then `req_config` → `config_start` high for 16 cycles. Drive `config_done` at cycle 40 → `configured` = 1, `state` = 0.
- `req_config` with no done → IDLE after 1000000 cycles; `timeout_err` = 1. A subsequent `req_zcheck` clears `timeout_err`.
- After config, `req_record_on`, then `req_stim_finite` after 3 `frame_tick` → `rejected`. After the 8th tick, `state` = 4 and `req_stim_finite` → strobe. A second request within 64 ticks → `rejected`; at the 64th tick → accepted.
- In STIM_INF, `req_record_off` → `stim_infinite_mode_stop` for 16 cycles, `state` = 6, then `record_start` = 0 and `state` = 0.
- Same-cycle `req_record_off` + `req_stim_finite` in RECORD → record stops, no stim strobe, no `rejected`.
- `rst` asserted mid-`config_start` → all outputs 0 asynchronously; `configured` = 0.
